// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Per-router switch allocator. Each output port runs its own
//                round-robin arbiter with a wormhole lock (head to tail) and a
//                credit counter for the downstream input buffer. Allocation
//                is combinational from registered state and current inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int BUF_DEPTH = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int CRED_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0][PORT_W-1:0]  req_port,
    input  logic [NUM_PORTS-1:0]              req_tail,
    input  logic [NUM_PORTS-1:0]              credit_inc,
    output logic [NUM_PORTS-1:0]              grant,
    output logic [NUM_PORTS-1:0]              xbar_valid,
    output logic [NUM_PORTS-1:0][PORT_W-1:0]  xbar_sel,
    output logic                              credit_err
);

    localparam logic [CRED_W-1:0] C_CRED_FULL = CRED_W'(BUF_DEPTH);
    localparam logic [CRED_W-1:0] C_CRED_ONE  = CRED_W'(1);
    localparam logic [PORT_W-1:0] C_PORT_LAST = PORT_W'(NUM_PORTS - 1);
    localparam logic [PORT_W-1:0] C_PORT_ONE  = PORT_W'(1);
    localparam logic [PORT_W:0]   C_PORT_NUM  = (PORT_W + 1)'(NUM_PORTS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Registered per-output state
    lock_state_t         r_state   [NUM_PORTS];
    logic [PORT_W-1:0]   r_owner   [NUM_PORTS];
    logic [PORT_W-1:0]   r_rr_ptr  [NUM_PORTS];
    logic [CRED_W-1:0]   r_credit  [NUM_PORTS];
    logic                r_credit_err;

    // Next-state values
    lock_state_t         w_state_next  [NUM_PORTS];
    logic [PORT_W-1:0]   w_owner_next  [NUM_PORTS];
    logic [PORT_W-1:0]   w_rr_next     [NUM_PORTS];
    logic [CRED_W-1:0]   w_credit_next [NUM_PORTS];
    logic                w_err_set;

    // Per-output grant indication (winner index is carried on xbar_sel)
    logic [NUM_PORTS-1:0] w_out_gnt;

    // Parallel per-output arbitration: lock owner when locked, otherwise
    // round-robin search from rr_ptr; credits gate the final grant.
    always_comb begin : p_arb
        logic              found;
        logic [PORT_W-1:0] winner;
        logic [PORT_W:0]   idx;
        logic [PORT_W-1:0] cand;
        grant      = '0;
        xbar_valid = '0;
        xbar_sel   = '0;
        w_out_gnt  = '0;
        found      = 1'b0;
        winner     = '0;
        idx        = '0;
        cand       = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            found  = 1'b0;
            winner = '0;
            if (r_state[o] == ST_LOCKED) begin
                if (req_valid[r_owner[o]] && (req_port[r_owner[o]] == PORT_W'(o))) begin
                    found  = 1'b1;
                    winner = r_owner[o];
                end
            end else begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = {1'b0, r_rr_ptr[o]} + (PORT_W + 1)'(k);
                    if (idx >= C_PORT_NUM) begin
                        idx = idx - C_PORT_NUM;
                    end
                    cand = idx[PORT_W-1:0];
                    if (!found && req_valid[cand] && (req_port[cand] == PORT_W'(o))) begin
                        found  = 1'b1;
                        winner = cand;
                    end
                end
            end
            if (found && (r_credit[o] != '0) && !rst) begin
                w_out_gnt[o]  = 1'b1;
                xbar_valid[o] = 1'b1;
                xbar_sel[o]   = winner;
                grant[winner] = 1'b1;
            end
        end
    end

    // Next-state: credit accounting, pointer advance and lock transitions
    always_comb begin
        w_err_set = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_state_next[o]  = r_state[o];
            w_owner_next[o]  = r_owner[o];
            w_rr_next[o]     = r_rr_ptr[o];
            w_credit_next[o] = r_credit[o];

            // A grant and a returned credit in the same cycle cancel out
            if (w_out_gnt[o] && !credit_inc[o]) begin
                w_credit_next[o] = r_credit[o] - C_CRED_ONE;
            end else if (!w_out_gnt[o] && credit_inc[o]) begin
                if (r_credit[o] == C_CRED_FULL) begin
                    w_err_set = 1'b1;
                end else begin
                    w_credit_next[o] = r_credit[o] + C_CRED_ONE;
                end
            end

            if (w_out_gnt[o]) begin
                if (r_state[o] == ST_IDLE) begin
                    w_rr_next[o] = (xbar_sel[o] == C_PORT_LAST) ? '0 : (xbar_sel[o] + C_PORT_ONE);
                    if (!req_tail[xbar_sel[o]]) begin
                        w_state_next[o] = ST_LOCKED;
                        w_owner_next[o] = xbar_sel[o];
                    end
                end else if (req_tail[r_owner[o]]) begin
                    w_state_next[o] = ST_IDLE;
                end
            end
        end
    end

    // State registers with asynchronous reset to full credit, idle, pointer 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_state[o]  <= ST_IDLE;
                r_owner[o]  <= '0;
                r_rr_ptr[o] <= '0;
                r_credit[o] <= C_CRED_FULL;
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_state[o]  <= w_state_next[o];
                r_owner[o]  <= w_owner_next[o];
                r_rr_ptr[o] <= w_rr_next[o];
                r_credit[o] <= w_credit_next[o];
            end
            r_credit_err <= r_credit_err | w_err_set;
        end
    end

    assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_allocator
//  Description : Self-checking bench for switch_allocator. Each scenario task
//                drives one cycle at a time, pushes the expected outputs to a
//                scoreboard queue and pops/compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

    localparam int NP = 5;
    localparam int PW = 3;

    logic                   clk;
    logic                   rst;
    logic [NP-1:0]          req_valid;
    logic [NP-1:0][PW-1:0]  req_port;
    logic [NP-1:0]          req_tail;
    logic [NP-1:0]          credit_inc;
    logic [NP-1:0]          grant;
    logic [NP-1:0]          xbar_valid;
    logic [NP-1:0][PW-1:0]  xbar_sel;
    logic                   credit_err;

    typedef struct {
        string          name;
        logic [NP-1:0]  g;
        logic [NP-1:0]  v;
        logic [NP*PW-1:0] s;
        logic           err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    switch_allocator #(.NUM_PORTS(NP), .BUF_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_port   (req_port),
        .req_tail   (req_tail),
        .credit_inc (credit_inc),
        .grant      (grant),
        .xbar_valid (xbar_valid),
        .xbar_sel   (xbar_sel),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NP*PW-1:0] sel_of(int o, int i);
        logic [NP*PW-1:0] r;
        r = '0;
        r[o*PW +: PW] = PW'(i);
        return r;
    endfunction

    function automatic void push(string nm, logic [NP-1:0] g, logic [NP-1:0] v,
                                 logic [NP*PW-1:0] s, logic err);
        exp_t e;
        e.name = nm;
        e.g    = g;
        e.v    = v;
        e.s    = s;
        e.err  = err;
        exp_q.push_back(e);
    endfunction

    task automatic clear_inputs();
        req_valid  = '0;
        req_port   = '0;
        req_tail   = '0;
        credit_inc = '0;
    endtask

    task automatic req(int i, int o, logic tail);
        req_valid[i] = 1'b1;
        req_port[i]  = PW'(o);
        req_tail[i]  = tail;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Outputs forced low during reset; first cycle after release grants.
    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            clear_inputs();
            req(0, 1, 1'b1);
            if (c == 0) begin
                rst        = 1'b1;
                credit_inc = '1;
                push("reset_outputs", '0, '0, '0, 1'b0);
            end else begin
                rst = 1'b0;
                push("reset_release", 5'b00001, 5'b00010, sel_of(1, 0), 1'b0);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({grant, xbar_valid, xbar_sel, credit_err} !== {e.g, e.v, e.s, e.err})
                $display("FAIL %s: got grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b, want grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b",
                         e.name, grant, xbar_valid, xbar_sel, credit_err, e.g, e.v, e.s, e.err);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    // Inputs 0 and 2 contend for output 1 with single-flit packets.
    task automatic test_single_flit();
        exp_t e;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            req(0, 1, 1'b1);
            req(2, 1, 1'b1);
            case (c)
                0: push("rr_first",  5'b00001, 5'b00010, sel_of(1, 0), 1'b0);
                1: push("rr_second", 5'b00100, 5'b00010, sel_of(1, 2), 1'b0);
                default: push("rr_wrap", 5'b00001, 5'b00010, sel_of(1, 0), 1'b0);
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({grant, xbar_valid, xbar_sel, credit_err} !== {e.g, e.v, e.s, e.err})
                $display("FAIL %s: got grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b, want grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b",
                         e.name, grant, xbar_valid, xbar_sel, credit_err, e.g, e.v, e.s, e.err);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    // Input 3 holds output 0 for a 3-flit packet while input 1 waits.
    // Credits are returned every cycle so each grant leaves the count at 4.
    task automatic test_wormhole();
        exp_t e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            credit_inc[0] = 1'b1;
            case (c)
                0: begin
                    req(2, 0, 1'b1);
                    push("wh_setup", 5'b00100, 5'b00001, sel_of(0, 2), 1'b0);
                end
                1, 2, 3: begin
                    req(3, 0, (c == 3));
                    req(1, 0, 1'b1);
                    push((c == 1) ? "wh_head" : (c == 2) ? "wh_body" : "wh_tail",
                         5'b01000, 5'b00001, sel_of(0, 3), 1'b0);
                end
                default: begin
                    req(1, 0, 1'b1);
                    push("wh_release", 5'b00010, 5'b00001, sel_of(0, 1), 1'b0);
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({grant, xbar_valid, xbar_sel, credit_err} !== {e.g, e.v, e.s, e.err})
                $display("FAIL %s: got grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b, want grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b",
                         e.name, grant, xbar_valid, xbar_sel, credit_err, e.g, e.v, e.s, e.err);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    // Input 3 streams single flits into output 4 until credits run out.
    task automatic test_credit();
        exp_t e;
        logic gnt_exp;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            clear_inputs();
            req(3, 4, 1'b1);
            credit_inc[4] = (c == 5) || (c == 7) || (c == 8);
            gnt_exp = (c < 4) || (c == 6) || (c == 8) || (c == 9);
            if (gnt_exp)
                push($sformatf("credit_c%0d", c), 5'b01000, 5'b10000, sel_of(4, 3), 1'b0);
            else
                push($sformatf("credit_c%0d", c), '0, '0, '0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({grant, xbar_valid, xbar_sel, credit_err} !== {e.g, e.v, e.s, e.err})
                $display("FAIL %s: got grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b, want grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b",
                         e.name, grant, xbar_valid, xbar_sel, credit_err, e.g, e.v, e.s, e.err);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    // Independent outputs allocate in the same cycle.
    task automatic test_parallel();
        exp_t e;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    req(0, 2, 1'b1);
                    req(1, 3, 1'b1);
                    req(4, 0, 1'b1);
                    push("par_three", 5'b10011, 5'b01101,
                         sel_of(2, 0) | sel_of(3, 1) | sel_of(0, 4), 1'b0);
                end
                1: begin
                    req(0, 2, 1'b1);
                    req(2, 2, 1'b1);
                    push("par_rr_out2", 5'b00100, 5'b00100, sel_of(2, 2), 1'b0);
                end
                default: begin
                    req(0, 2, 1'b1);
                    req(2, 2, 1'b1);
                    push("par_rr_out2_wrap", 5'b00001, 5'b00100, sel_of(2, 0), 1'b0);
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({grant, xbar_valid, xbar_sel, credit_err} !== {e.g, e.v, e.s, e.err})
                $display("FAIL %s: got grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b, want grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b",
                         e.name, grant, xbar_valid, xbar_sel, credit_err, e.g, e.v, e.s, e.err);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    // Destinations beyond the last port must never be granted.
    task automatic test_invalid();
        exp_t e;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            req(0, 7, 1'b1);
            req(1, 5, 1'b0);
            req(4, 6, 1'b1);
            push($sformatf("invalid_c%0d", c), '0, '0, '0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({grant, xbar_valid, xbar_sel, credit_err} !== {e.g, e.v, e.s, e.err})
                $display("FAIL %s: got grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b, want grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b",
                         e.name, grant, xbar_valid, xbar_sel, credit_err, e.g, e.v, e.s, e.err);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    // Credit overflow error, then a reset in the middle of a locked packet.
    task automatic test_error_reset();
        exp_t e;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            clear_inputs();
            rst = 1'b0;
            if (c == 0) begin
                credit_inc[2] = 1'b1;
                push("err_overflow", '0, '0, '0, 1'b0);
            end else if (c <= 5) begin
                req(0, 2, 1'b1);
                if (c <= 4)
                    push($sformatf("err_credit_hold_c%0d", c), 5'b00001, 5'b00100, sel_of(2, 0), 1'b1);
                else
                    push("err_credit_hold_empty", '0, '0, '0, 1'b1);
            end else if (c <= 7) begin
                req(1, 0, 1'b0);
                push((c == 6) ? "lock_head" : "lock_body", 5'b00010, 5'b00001, sel_of(0, 1), 1'b1);
            end else if (c == 8) begin
                req(1, 0, 1'b0);
                rst = 1'b1;
                push("mid_packet_reset", '0, '0, '0, 1'b0);
            end else begin
                req(3, 0, 1'b1);
                if (c <= 12)
                    push($sformatf("post_reset_c%0d", c), 5'b01000, 5'b00001, sel_of(0, 3), 1'b0);
                else
                    push("post_reset_empty", '0, '0, '0, 1'b0);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({grant, xbar_valid, xbar_sel, credit_err} !== {e.g, e.v, e.s, e.err})
                $display("FAIL %s: got grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b, want grant=%b xbar_valid=%b xbar_sel=%h credit_err=%b",
                         e.name, grant, xbar_valid, xbar_sel, credit_err, e.g, e.v, e.s, e.err);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_flit();
        test_wormhole();
        test_credit();
        test_parallel();
        test_invalid();
        test_error_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
